// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU controller)
// and the iterative-shift state machine encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_XOR = 4'b0001,
    OP_ADD = 4'b0010,
    OP_OR  = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_SLT = 4'b1101
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU operations. Shift codes and unknown codes
// yield zero here; shifts are sequenced by the top level.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_EQ:   y = DATA_WIDTH'(a == b);
      OP_SLT:  y = DATA_WIDTH'($signed(a) < $signed(b));
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU with valid/ready handshake; shifts are performed one bit
// per cycle in the result register instead of through a barrel shifter.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  alu_state_t             state_reg, state_next;
  logic [3:0]             op_reg, op_next;
  logic [SHAMT_WIDTH-1:0] count_reg, count_next;
  logic [DATA_WIDTH-1:0]  result_reg, result_next;

  logic [DATA_WIDTH-1:0]  core_result;
  logic [DATA_WIDTH-1:0]  sll_step, srl_step, sra_step;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .op(Operation),
    .a (SrcA),
    .b (SrcB),
    .y (core_result)
  );

  assign shamt    = SrcB[SHAMT_WIDTH-1:0];
  assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

  // One-bit shift candidates of the result register.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_step
    if (gi == 0) begin : g_lsb
      assign sll_step[gi] = 1'b0;
    end else begin : g_lsb_n
      assign sll_step[gi] = result_reg[gi-1];
    end
    if (gi == DATA_WIDTH - 1) begin : g_msb
      assign srl_step[gi] = 1'b0;
      assign sra_step[gi] = result_reg[gi];
    end else begin : g_msb_n
      assign srl_step[gi] = result_reg[gi+1];
      assign sra_step[gi] = result_reg[gi+1];
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    count_next  = count_reg;
    result_next = result_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_next = Operation;
          if (is_shift && (shamt != '0)) begin
            result_next = SrcA;
            count_next  = shamt;
            state_next  = SHIFT;
          end else begin
            // A zero-distance shift passes SrcA through unchanged.
            result_next = is_shift ? SrcA : core_result;
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        case (op_reg)
          OP_SLL:  result_next = sll_step;
          OP_SRL:  result_next = srl_step;
          default: result_next = sra_step;
        endcase
        count_next = count_reg - SHAMT_WIDTH'(1);
        if (count_reg == SHAMT_WIDTH'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      count_reg  <= count_next;
      result_reg <= result_next;
    end
  end

  assign ALUResult = result_reg;
  assign Zero      = (result_reg == '0);

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative: hand-computed results,
// latencies, handshake, backpressure and mid-operation reset.
module tb_alu_iterative;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int checks   = 0;
  int failures = 0;

  alu_iterative #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Operation(Operation),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .Zero     (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request with out_ready held high; inputs are scrambled after
  // acceptance so any leakage into the in-flight result shows up.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    logic busy_ok;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    Operation = 4'($urandom);
    SrcA      = $urandom;
    SrcB      = $urandom;
    lat       = 1;
    busy_ok   = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, ALUResult, exp_res);
    check({tag, "_zero"}, 32'(Zero), 32'(exp_res == 32'd0));
    check({tag, "_busy"}, 32'(busy_ok && !in_ready), 32'd1);
    $display("op %s: op=%04b result=0x%08h zero=%0b latency=%0d", tag, op, ALUResult, Zero, lat);
    @(posedge clk);
    #1;
    check({tag, "_consumed"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    Operation = 4'b0000;
    SrcA      = 32'd0;
    SrcB      = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", ALUResult, 32'd0);
    check("reset_zero", 32'(Zero), 32'd1);
    rst = 1'b0;

    do_op("add_wrap",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
    do_op("sub_eq",    4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1);
    do_op("eq_true",   4'b1000, 32'h1234_5678, 32'h1234_5678, 32'h0000_0001, 1);
    do_op("eq_false",  4'b1000, 32'h1234_5678, 32'h1234_5679, 32'h0000_0000, 1);
    do_op("slt_neg",   4'b1101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
    do_op("slt_pos",   4'b1101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    do_op("and",       4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
    do_op("xor",       4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1);
    do_op("or",        4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    do_op("illegal",   4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    do_op("sra_31",    4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32);
    do_op("sra_4",     4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5);
    do_op("sll_0",     4'b0100, 32'h0000_00A5, 32'h0000_0000, 32'h0000_00A5, 1);
    do_op("sll_31",    4'b0100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32);
    do_op("srl_4",     4'b0101, 32'h0000_00F0, 32'h0000_0004, 32'h0000_000F, 5);
    do_op("srl_hi_b",  4'b0101, 32'h0000_0100, 32'hFFFF_FF25, 32'h0000_0008, 6);
    do_op("srl_to_0",  4'b0101, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 2);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    Operation = 4'b0010;
    SrcA      = 32'h0000_0010;
    SrcB      = 32'h0000_0020;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    check("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      Operation = 4'b0110;
      SrcA      = $urandom;
      SrcB      = $urandom;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hold_result", ALUResult, 32'h0000_0030);
      check("bp_hold_flags", {29'd0, out_valid, in_ready, Zero}, 32'b100);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
    $display("op backpressure: result held 0x00000030 for 10 stalled cycles");

    // Reset in the middle of a 20-bit shift.
    Operation = 4'b0100;
    SrcA      = 32'h0000_0001;
    SrcB      = 32'd20;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", ALUResult, 32'd0);
    check("midrst_zero", 32'(Zero), 32'd1);
    begin
      logic seen_valid;
      seen_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen_valid = 1'b1;
      end
      check("midrst_no_valid", 32'(seen_valid), 32'd0);
    end
    $display("op midreset: sll 20 aborted, outputs at reset values");
    do_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller. It also takes two operands and returns a result and a zero flag over a valid/ready handshake. Logic, arithmetic, compare and branch-equality operations complete in one cycle. Shifts run iteratively, one bit per cycle, so the datapath needs no barrel shifter. It sits between the register-read stage and the writeback/branch logic of the multi-cycle core.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- SHAMT_WIDTH, 5, shift-amount width (log2 DATA_WIDTH)

Ports:
- clk  input  1  clock; single clock domain
- rst  input  1  reset; synchronous and active-high
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- Operation  input  4  operation code (encoding below)
- SrcA  input  DATA_WIDTH  operand A
- SrcB  input  DATA_WIDTH  operand B; shift amount is SrcB[SHAMT_WIDTH-1:0]
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes the result
- ALUResult  output  DATA_WIDTH  result
- Zero  output  1  ALUResult == 0

## Operation
- Encoding:
  - 0000 AND
  - 0001 XOR
  - 0010 ADD
  - 0011 OR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SRA
  - 1000 EQ (result 1 if SrcA==SrcB, else 0)
  - 1101 SLT (signed; result 1/0)
  - Any other code: result 0, single-cycle.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag. SLT compares in two's complement. SRA replicates the MSB.
- State machine:
  - IDLE: in_ready=1. On in_valid, latch Operation, SrcA and shamt.
    - Shift op with shamt>0: go to SHIFT, with the count register set to shamt.
    - Otherwise: compute the result into the result register and go to DONE.
  - SHIFT: each cycle, shift the result register by one bit (SLL: left, zero-fill; SRL: right, zero-fill; SRA: right, sign-fill) and decrement the count. When count==1, the final shift occurs and the next state is DONE.
  - DONE: out_valid=1. ALUResult and Zero are held stable until out_ready=1, then go to IDLE.
- in_ready=0 in SHIFT and DONE; inputs are ignored there.
- Zero is derived from the registered ALUResult and is valid only while out_valid=1.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, ALUResult=0, Zero=1, count=0.
- A request is accepted at the rising edge where in_valid && in_ready.
- Non-shift op, or shift with shamt=0: out_valid high in the cycle after acceptance (latency 1).
- Shift with shamt=n>0: out_valid high n+1 cycles after acceptance.
- out_valid && out_ready at an edge: out_valid=0 and in_ready=1 in the next cycle. Maximum throughput is one op per 2 cycles; there is no accept-during-DONE bypass.
- out_ready held high before out_valid: the result is consumed on the first DONE cycle.
- Reset asserted in any state (including mid-SHIFT) returns to reset values at the next edge. The in-flight op is discarded and no out_valid pulse is produced.
- Input changes while in_ready=0 have no effect on the in-flight result.

## Structure
- Shared package alu_pkg:
  - alu_op_t enum for the ten codes above, shared with the ALU controller.
  - alu_state_t enum {IDLE, SHIFT, DONE}.
- Sub-module alu_core: purely combinational single-cycle ops (AND/XOR/OR/ADD/SUB/EQ/SLT/default). It is instantiated once.
- Top level holds the FSM, the count register, the shift register/result register, and the handshake.

## Test plan
- ADD: SrcA=0x7FFFFFFF, SrcB=1, op 0010 -> ALUResult=0x80000000, Zero=0, out_valid 1 cycle after accept.
- SUB/EQ: SrcA=SrcB=0x12345678, op 0110 -> result 0, Zero=1; op 1000 -> result 1, Zero=0.
- SLT/SRA: SLT with SrcA=0xFFFFFFFF, SrcB=1 -> result 1. SRA with SrcA=0x80000000, shamt=31 -> 0xFFFFFFFF, out_valid exactly 32 cycles after accept, in_ready=0 throughout.
- Shift edges: SLL with shamt=0 and SrcA=0xA5 -> 0xA5 in 1 cycle. SRL with SrcA=0xF0 and shamt=4 -> 0x0F in 5 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> ALUResult/Zero stable and in_ready=0. Raise out_ready -> next cycle out_valid=0, in_ready=1. Change inputs during the stall -> no effect.
- Reset mid-op: start SLL with shamt=20, assert rst at cycle 5 -> next cycle all outputs at reset values, no out_valid. A new ADD 2+3 afterwards -> 5.
